// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: shared types and constants for the bit serializer.
//   bitser_state_t       - shifter FSM state (IDLE, SHIFT)
//   BITSER_IDLE_FILL     - value driven on x when no data bit is present
//   BITSER_DEFAULT_WIDTH - default word length
package bit_serializer_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } bitser_state_t;

    localparam logic BITSER_IDLE_FILL     = 1'b0;
    localparam int   BITSER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bitser_hold.sv
// bitser_hold: one-word skid register sitting in front of the shifter.
//   clk, reset - clock, asynchronous active-high reset (empties the buffer)
//   i_load     - capture i_data; marks the buffer full
//   i_take     - shifter consumed o_data; marks the buffer empty
//   i_data     - word to capture
//   o_data     - buffered word
//   o_full     - buffer holds a word
module bitser_hold
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = BITSER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_take,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else begin
            if (i_load)
                r_data <= i_data;
            if (i_load)
                r_full <= 1'b1;
            else if (i_take)
                r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end feeding one bit per clock to the detector.
//   clk, reset - clock, asynchronous active-high reset
//   din        - WIDTH-bit word to serialize
//   din_valid  - din is valid this cycle
//   din_ready  - block accepts din this cycle (transfer = din_valid && din_ready)
//   x          - serial bit, idle-fill value when x_valid is low
//   x_valid    - x carries a data bit
//   busy       - shifter or hold buffer occupied
// Build option: define BIT_SERIALIZER_SKID_EN to add a one-word hold buffer with a
// registered din_ready (up to two words outstanding, same latency).
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = BITSER_DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    bitser_state_t    r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [WIDTH-1:0] w_load_word;
    logic             w_last, w_xfer, w_load, w_hold_full;

    assign w_last = (r_state == SHIFT) && (r_cnt == LAST);
    assign w_xfer = din_valid && din_ready;

`ifdef BIT_SERIALIZER_SKID_EN
    logic             w_direct, w_hold_load, w_hold_take;
    logic [WIDTH-1:0] w_hold_q;

    // A word bypasses the buffer only when the shifter can take it right now
    // and nothing older is waiting; otherwise it parks in the buffer.
    assign w_direct    = w_xfer && !w_hold_full && (r_state == IDLE || w_last);
    assign w_hold_load = w_xfer && !w_direct;
    assign w_hold_take = w_last && w_hold_full;
    assign w_load      = w_direct || w_hold_take;
    assign w_load_word = w_hold_take ? w_hold_q : din;
    // Ready comes from the buffer flag; reset gating keeps it low while reset is held.
    assign din_ready   = !reset && !w_hold_full;

    bitser_hold #(.WIDTH(WIDTH)) u_hold (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_hold_load),
        .i_take (w_hold_take),
        .i_data (din),
        .o_data (w_hold_q),
        .o_full (w_hold_full)
    );
`else
    assign w_hold_full = 1'b0;
    assign w_load      = w_xfer;
    assign w_load_word = din;
    // Accepting on the last bit is what makes back-to-back words gapless.
    assign din_ready   = !reset && (r_state == IDLE || w_last);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_shift_nxt = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
        if (w_load) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
            w_shift_nxt = w_load_word;
        end else if (r_state == IDLE || w_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end
        // The outgoing bit always sits at a fixed end of the shifter, so x is flop-driven.
        x_valid = (r_state == SHIFT);
        x       = x_valid ? (LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1]) : BITSER_IDLE_FILL;
        busy    = x_valid || w_hold_full;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed self-checking bench for bit_serializer (MSB- and LSB-first instances).
module tb_bit_serializer;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] din       = '0;
    logic       din_valid = 1'b0;
    logic       sel       = 1'b0;
    logic       m_ready, m_x, m_xv, m_busy;
    logic       l_ready, l_x, l_xv, l_busy;
    logic       o_ready, o_x, o_xv, o_busy;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (m_ready),
        .x         (m_x),
        .x_valid   (m_xv),
        .busy      (m_busy)
    );

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (l_ready),
        .x         (l_x),
        .x_valid   (l_xv),
        .busy      (l_busy)
    );

    assign o_ready = sel ? l_ready : m_ready;
    assign o_x     = sel ? l_x     : m_x;
    assign o_xv    = sel ? l_xv    : m_xv;
    assign o_busy  = sel ? l_busy  : m_busy;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Offers nw words back-to-back for ncyc cycles; sample c is cycle T+1+c after the
    // first edge. Records valid bits (first bit ends up most significant), per-cycle
    // x_valid/din_ready/busy, a 1101 detector on x, and the accept cycle of each word.
    task automatic run(input logic [7:0] w [4], input int nw, input int ncyc,
                       output logic [63:0] bits, output logic [63:0] vs,
                       output logic [63:0] rs, output logic [63:0] bs,
                       output logic [63:0] zs, output int acc [4], output int fill_bad);
        int         idx;
        logic       xfer;
        logic [3:0] hist;
        idx      = 0;
        hist     = '0;
        bits     = '0;
        vs       = '0;
        rs       = '0;
        bs       = '0;
        zs       = '0;
        fill_bad = 0;
        for (int k = 0; k < 4; k++) acc[k] = -1;
        din       = w[0];
        din_valid = (nw > 0);
        for (int c = 0; c < ncyc; c++) begin
            xfer = din_valid && o_ready;
            @(posedge clk);
            #1;
            if (xfer) begin
                acc[idx] = c;
                idx++;
                din_valid = (idx < nw);
                if (idx < nw) din = w[idx];
            end
            vs[c] = o_xv;
            rs[c] = o_ready;
            bs[c] = o_busy;
            if (o_xv) bits = {bits[62:0], o_x};
            else if (o_x !== 1'b0) fill_bad++;
            hist  = {hist[2:0], o_x};
            zs[c] = (hist == 4'b1101);
        end
    endtask

    logic [7:0]  w [4];
    logic [63:0] bits, vs, rs, bs, zs;
    int          acc [4];
    int          fb;

    initial begin
        #12;
        check("rst_x",     {m_x, l_x},         2'b00);
        check("rst_xv",    {m_xv, l_xv},       2'b00);
        check("rst_busy",  {m_busy, l_busy},   2'b00);
        check("rst_ready", {m_ready, l_ready}, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", {m_ready, l_ready}, 2'b11);
        check("post_rst_busy",  {m_busy, l_busy},   2'b00);

        // single word D0, MSB first
        w = '{8'hD0, 8'h00, 8'h00, 8'h00};
        run(w, 1, 10, bits, vs, rs, bs, zs, acc, fb);
        check("d0_bits",  bits[7:0], 8'hD0);
        check("d0_valid", vs[9:0],   10'h0FF);
        check("d0_busy",  bs[9:0],   10'h0FF);
        check("d0_det",   zs[9:0],   10'h008);
        check("d0_fill",  fb,        0);
`ifdef BIT_SERIALIZER_SKID_EN
        check("d0_ready", rs[9:0],   10'h3FF);
`else
        check("d0_ready", rs[9:0],   10'h380);
`endif

        // two words back to back
        w = '{8'h0D, 8'hA5, 8'h00, 8'h00};
        run(w, 2, 18, bits, vs, rs, bs, zs, acc, fb);
        check("b2b_bits",  bits[15:0], 16'h0DA5);
        check("b2b_valid", vs[17:0],   18'h0FFFF);
        check("b2b_fill",  fb,         0);
`ifdef BIT_SERIALIZER_SKID_EN
        check("b2b_acc1",  acc[1],     1);
`else
        check("b2b_acc1",  acc[1],     8);
        check("b2b_stall", rs[3],      1'b0);
`endif

        // three words offered continuously
        w = '{8'h0D, 8'hA5, 8'h3C, 8'h00};
        run(w, 3, 28, bits, vs, rs, bs, zs, acc, fb);
        check("w3_bits",  bits[23:0], 24'h0DA53C);
        check("w3_valid", vs[27:0],   28'h0FFFFFF);
        check("w3_busy",  bs[27:0],   28'h0FFFFFF);
`ifdef BIT_SERIALIZER_SKID_EN
        check("w3_acc",   {acc[0][7:0], acc[1][7:0], acc[2][7:0]}, 24'h000109);
        check("w3_ready", rs[27:0],   28'hFFF0101);
`else
        check("w3_acc",   {acc[0][7:0], acc[1][7:0], acc[2][7:0]}, 24'h000810);
        check("w3_ready", rs[27:0],   28'hF808080);
`endif

        // LSB-first instance
        sel = 1'b1;
        w = '{8'h01, 8'h00, 8'h00, 8'h00};
        run(w, 1, 9, bits, vs, rs, bs, zs, acc, fb);
        check("lsb01_bits",  bits[7:0], 8'h80);
        check("lsb01_valid", vs[8:0],   9'h0FF);
        w = '{8'hB4, 8'h00, 8'h00, 8'h00};
        run(w, 1, 9, bits, vs, rs, bs, zs, acc, fb);
        check("lsbb4_bits",  bits[7:0], 8'h2D);
        sel = 1'b0;

        // reset during the 4th bit of FF
        w = '{8'hFF, 8'h00, 8'h00, 8'h00};
        run(w, 1, 4, bits, vs, rs, bs, zs, acc, fb);
        check("ff_partial", {vs[3:0], bits[3:0]}, 8'hFF);
        reset = 1'b1;
        #1;
        check("mid_rst_x",     o_x,     1'b0);
        check("mid_rst_xv",    o_xv,    1'b0);
        check("mid_rst_busy",  o_busy,  1'b0);
        check("mid_rst_ready", o_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rel_ready", o_ready, 1'b1);
        run(w, 0, 12, bits, vs, rs, bs, zs, acc, fb);
        check("rel_quiet", vs[11:0], 12'h000);
        check("rel_fill",  fb,       0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
